phase_decoder: RTL and testbench

- Receive-side counterpart of the 4-phase step sequencer.
- Samples a 4-bit full-step phase bus (0011 -> 0110 -> 1100 -> 1001 forward) arriving from off-chip or from another clock domain.
- Synchronizes the bus, decodes direction and step events, and keeps a signed step position.
- Flags skipped steps and illegal patterns. Used for closed-loop step verification and motor-position monitoring on the board.

---
 rtl/phase_pkg.sv | 41 ++++
 rtl/phase_sync.sv | 23 ++
 rtl/phase_decoder.sv | 109 ++++++++++
 tb/tb_phase_decoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared definitions for the 4-phase full-step bus: pattern constants, decode
// helper, decoder FSM states and phase-delta meanings.
package phase_pkg;

  // Forward full-step order; reverse walks this table backwards.
  localparam logic [3:0] PH_0 = 4'b0011;
  localparam logic [3:0] PH_1 = 4'b0110;
  localparam logic [3:0] PH_2 = 4'b1100;
  localparam logic [3:0] PH_3 = 4'b1001;

  // (idx - last_idx) mod 4
  localparam logic [1:0] D_HOLD = 2'd0;
  localparam logic [1:0] D_FWD  = 2'd1;
  localparam logic [1:0] D_SKIP = 2'd2;
  localparam logic [1:0] D_REV  = 2'd3;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] idx;
  } ph_dec_t;

  function automatic ph_dec_t decode_phase(input logic [3:0] ph);
    ph_dec_t r;
    r.legal = 1'b1;
    r.idx   = 2'd0;
    case (ph)
      PH_0:    r.idx = 2'd0;
      PH_1:    r.idx = 2'd1;
      PH_2:    r.idx = 2'd2;
      PH_3:    r.idx = 2'd3;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/phase_sync.sv
// Multi-flop synchronizer for the 4-bit phase bus; resets every stage to 0000.
module phase_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] phase_in,
  output logic [3:0] ph_s
);

  logic [SYNC_STAGES-1:0][3:0] stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], phase_in};
    end
  end

  assign ph_s = stage[SYNC_STAGES-1];

endmodule

// File: rtl/phase_decoder.sv
// Decodes a synchronized 4-phase step bus into direction, step strobes, a signed
// position and skip/illegal error flags. Outputs lag phase_in by SYNC_STAGES+1 edges.
module phase_decoder
  import phase_pkg::*;
#(
  parameter int POS_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  phase_in,
  input  logic                        clr_pos,
  input  logic                        clr_err,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        dir,
  output logic                        step_pulse,
  output logic                        err_skip,
  output logic                        err_illegal,
  output logic                        err_sticky,
  output logic                        locked
);

  logic [3:0] ph_s;
  ph_dec_t    dec;
  state_t     state;
  logic [1:0] last_idx;
  logic [1:0] delta;
  logic       ev_lock, ev_fwd, ev_rev, ev_skip, ev_illegal;

  phase_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .phase_in (phase_in),
    .ph_s     (ph_s)
  );

  assign dec   = decode_phase(ph_s);
  assign delta = dec.idx - last_idx;

  always_comb begin
    ev_lock    = 1'b0;
    ev_fwd     = 1'b0;
    ev_rev     = 1'b0;
    ev_skip    = 1'b0;
    ev_illegal = 1'b0;
    if (state == UNLOCKED) begin
      // Illegal patterns while unlocked are expected during power-up; stay quiet.
      ev_lock = dec.legal;
    end else if (!dec.legal) begin
      ev_illegal = 1'b1;
    end else begin
      ev_fwd  = (delta == D_FWD);
      ev_rev  = (delta == D_REV);
      ev_skip = (delta == D_SKIP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= UNLOCKED;
      last_idx    <= 2'd0;
      position    <= '0;
      dir         <= 1'b0;
      step_pulse  <= 1'b0;
      err_skip    <= 1'b0;
      err_illegal <= 1'b0;
      err_sticky  <= 1'b0;
      locked      <= 1'b0;
    end else begin
      step_pulse  <= ev_fwd | ev_rev;
      err_skip    <= ev_skip;
      err_illegal <= ev_illegal;

      if (ev_lock) begin
        state  <= LOCKED;
        locked <= 1'b1;
      end else if (ev_illegal) begin
        state  <= UNLOCKED;
        locked <= 1'b0;
      end

      // A skip still resyncs the reference; an illegal pattern keeps the old one.
      if (ev_lock || ev_fwd || ev_rev || ev_skip) begin
        last_idx <= dec.idx;
      end

      if (ev_fwd) begin
        dir <= 1'b1;
      end else if (ev_rev) begin
        dir <= 1'b0;
      end

      if (clr_pos) begin
        position <= '0;
      end else if (ev_fwd) begin
        position <= position + POS_WIDTH'(1);
      end else if (ev_rev) begin
        position <= position - POS_WIDTH'(1);
      end

      if (ev_skip || ev_illegal) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phase_decoder.sv
// Directed-vector bench for phase_decoder: lock, forward/reverse counting, skip,
// illegal patterns, clears and position wrap at the default 16-bit width.
module tb_phase_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  phase_in = 4'b0011;
  logic        clr_pos = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] position;
  logic        dir, step_pulse, err_skip, err_illegal, err_sticky, locked;

  int checks = 0;
  int errors = 0;
  int cnt_step = 0;
  int cnt_skip = 0;
  int cnt_ill  = 0;

  logic [3:0] pats [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};

  phase_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .phase_in    (phase_in),
    .clr_pos     (clr_pos),
    .clr_err     (clr_err),
    .position    (position),
    .dir         (dir),
    .step_pulse  (step_pulse),
    .err_skip    (err_skip),
    .err_illegal (err_illegal),
    .err_sticky  (err_sticky),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  // Strobes are one posedge wide, so sampling on negedge counts each exactly once.
  always @(negedge clk) begin
    if (!rst) begin
      cnt_step = cnt_step + int'(step_pulse);
      cnt_skip = cnt_skip + int'(err_skip);
      cnt_ill  = cnt_ill  + int'(err_illegal);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] p, input int n);
    phase_in = p;
    tick(n);
  endtask

  task automatic zero_counts();
    cnt_step = 0;
    cnt_skip = 0;
    cnt_ill  = 0;
  endtask

  task automatic test_reset();
    tick(1);
    checks++;
    if ({position, dir, step_pulse, err_skip, err_illegal, err_sticky, locked} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got pos=%h flags=%b, want all zero", position,
               {dir, step_pulse, err_skip, err_illegal, err_sticky, locked});
    end
    @(negedge clk);
    rst = 1'b0;
    zero_counts();
    tick(2);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: locked=%b want 0", locked); end
    tick(1);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_latency: locked=%b want 1", locked); end
    tick(10);
    checks++;
    if (position !== 16'd0 || cnt_step != 0) begin
      errors++;
      $display("FAIL lock_no_count: pos=%h steps=%0d want 0/0", position, cnt_step);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({position, dir, step_pulse, err_skip, err_illegal, err_sticky, locked} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset: got pos=%h locked=%b, want zeros", position, locked);
    end
    tick(2);
    rst = 1'b0;
    tick(4);
    checks++;
    if (locked !== 1'b1 || position !== 16'd0) begin
      errors++;
      $display("FAIL relock_after_reset: locked=%b pos=%h want 1/0000", locked, position);
    end
  endtask

  task automatic test_forward();
    zero_counts();
    phase_in = 4'b0110;
    tick(2);
    checks++;
    if (step_pulse !== 1'b0) begin errors++; $display("FAIL step_early: step_pulse=%b want 0", step_pulse); end
    tick(1);
    checks++;
    if (step_pulse !== 1'b1 || position !== 16'd1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL step_latency: pulse=%b pos=%h dir=%b want 1/0001/1", step_pulse, position, dir);
    end
    tick(1);
    checks++;
    if (step_pulse !== 1'b0) begin errors++; $display("FAIL step_width: step_pulse=%b want 0", step_pulse); end
    tick(1);
    drive(4'b1100, 5);
    drive(4'b1001, 5);
    drive(4'b0011, 5);
    checks++;
    if (cnt_step != 4 || dir !== 1'b1 || position !== 16'd4 || cnt_skip != 0 || cnt_ill != 0) begin
      errors++;
      $display("FAIL forward_seq: steps=%0d dir=%b pos=%h skip=%0d ill=%0d want 4/1/0004/0/0",
               cnt_step, dir, position, cnt_skip, cnt_ill);
    end
  endtask

  task automatic test_reverse();
    zero_counts();
    drive(4'b1001, 5);
    drive(4'b1100, 5);
    checks++;
    if (cnt_step != 2 || dir !== 1'b0 || position !== 16'd2) begin
      errors++;
      $display("FAIL reverse_seq: steps=%0d dir=%b pos=%h want 2/0/0002", cnt_step, dir, position);
    end
    drive(4'b1100, 20);
    checks++;
    if (cnt_step != 2 || position !== 16'd2 || cnt_skip != 0 || cnt_ill != 0) begin
      errors++;
      $display("FAIL dwell: steps=%0d pos=%h want 2/0002", cnt_step, position);
    end
  endtask

  task automatic test_skip();
    drive(4'b0110, 5);
    drive(4'b0011, 5);
    zero_counts();
    phase_in = 4'b1100;
    tick(3);
    checks++;
    if (err_skip !== 1'b1 || err_sticky !== 1'b1 || position !== 16'd0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL skip_strobe: skip=%b sticky=%b pos=%h dir=%b want 1/1/0000/0",
               err_skip, err_sticky, position, dir);
    end
    tick(2);
    checks++;
    if (cnt_skip != 1 || cnt_step != 0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL skip_once: skips=%0d steps=%0d locked=%b want 1/0/1", cnt_skip, cnt_step, locked);
    end
    drive(4'b1001, 5);
    checks++;
    if (position !== 16'd1 || dir !== 1'b1 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL after_skip: pos=%h dir=%b sticky=%b want 0001/1/1", position, dir, err_sticky);
    end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    checks++;
    if (err_sticky !== 1'b0) begin errors++; $display("FAIL clr_err: sticky=%b want 0", err_sticky); end
  endtask

  task automatic test_illegal();
    zero_counts();
    phase_in = 4'b0101;
    clr_err  = 1'b1;
    tick(3);
    checks++;
    if (err_illegal !== 1'b1 || err_sticky !== 1'b1 || locked !== 1'b0 || position !== 16'd1) begin
      errors++;
      $display("FAIL illegal_strobe: ill=%b sticky=%b locked=%b pos=%h want 1/1/0/0001",
               err_illegal, err_sticky, locked, position);
    end
    tick(1);
    clr_err = 1'b0;
    checks++;
    if (err_sticky !== 1'b0 || err_illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: sticky=%b ill=%b want 0/0", err_sticky, err_illegal);
    end
    drive(4'b0000, 6);
    checks++;
    if (cnt_ill != 1 || cnt_skip != 0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL unlocked_quiet: ill=%0d skip=%0d locked=%b want 1/0/0", cnt_ill, cnt_skip, locked);
    end
    drive(4'b0110, 5);
    checks++;
    if (locked !== 1'b1 || cnt_step != 0 || position !== 16'd1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL relock: locked=%b steps=%0d pos=%h dir=%b want 1/0/0001/1",
               locked, cnt_step, position, dir);
    end
  endtask

  task automatic test_wrap();
    int idx;
    idx = 1;
    for (int k = 0; k < 32766; k++) begin
      idx = (idx + 1) % 4;
      phase_in = pats[idx];
      @(negedge clk);
    end
    tick(4);
    checks++;
    if (position !== 16'h7FFF) begin errors++; $display("FAIL reach_max: pos=%h want 7fff", position); end
    idx = (idx + 1) % 4;
    drive(pats[idx], 5);
    checks++;
    if (position !== 16'h8000 || dir !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pos: pos=%h dir=%b want 8000/1", position, dir);
    end
    idx = (idx + 1) % 4;
    phase_in = pats[idx];
    clr_pos  = 1'b1;
    tick(3);
    checks++;
    if (step_pulse !== 1'b1 || position !== 16'd0) begin
      errors++;
      $display("FAIL clr_pos_wins: pulse=%b pos=%h want 1/0000", step_pulse, position);
    end
    tick(2);
    clr_pos = 1'b0;
    idx = (idx + 3) % 4;
    drive(pats[idx], 5);
    checks++;
    if (position !== 16'hFFFF || dir !== 1'b0) begin
      errors++;
      $display("FAIL wrap_neg: pos=%h dir=%b want ffff/0", position, dir);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_skip();
    test_illegal();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
